// File: rtl/vehicle_plant.sv
// Vehicle plant: prescaled saturating speed integrator driven by
// accelerate/brake commands, plus a debounced obstacle sensor.
module vehicle_plant #(
  parameter int SPEED_W    = 8,
  parameter int SPEED_MAX  = 40,
  parameter int TICK_DIV   = 4,
  parameter int ACCEL_STEP = 1,
  parameter int BRAKE_STEP = 2,
  parameter int DRAG_STEP  = 0,
  parameter int DEBOUNCE   = 3
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               enable,
  input  logic               accelerate,
  input  logic               brake,
  input  logic               load_en,
  input  logic [SPEED_W-1:0] load_value,
  input  logic               obstacle_raw,
  output logic [SPEED_W-1:0] speed,
  output logic               obstacle,
  output logic               moving,
  output logic               update,
  output logic               fault
);

  localparam int XW = SPEED_W + 1;
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

  localparam logic [XW-1:0] MAX_X = XW'(SPEED_MAX);
  localparam logic [XW-1:0] ACC_X = XW'(ACCEL_STEP);
  localparam logic [XW-1:0] BRK_X = XW'(BRAKE_STEP);
  localparam logic [XW-1:0] DRG_X = XW'(DRAG_STEP);
  localparam logic [PW-1:0] PLAST = PW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DLAST = DW'(DEBOUNCE - 1);

  logic [SPEED_W-1:0] speed_q, speed_d;
  logic [PW-1:0]      pcnt_q, pcnt_d;
  logic               update_q, update_d;
  logic               fault_q, fault_d;
  logic               s1_q, s2_q;
  logic               obs_q, obs_d;
  logic [DW-1:0]      dcnt_q, dcnt_d;

  logic          tick;
  logic [XW-1:0] spd_x, load_x, sum_x;

  assign tick   = enable && (pcnt_q == PLAST);
  assign spd_x  = {1'b0, speed_q};
  assign load_x = {1'b0, load_value};
  assign sum_x  = spd_x + ACC_X;

  always_comb begin
    speed_d  = speed_q;
    pcnt_d   = pcnt_q;
    update_d = 1'b0;
    fault_d  = fault_q;
    if (enable) begin
      pcnt_d = tick ? '0 : pcnt_q + 1'b1;
    end
    if (load_en) begin
      pcnt_d   = '0;
      update_d = 1'b1;
      speed_d  = (load_x > MAX_X) ? MAX_X[SPEED_W-1:0]
                                  : load_value;
    end else if (tick) begin
      update_d = 1'b1;
      // simultaneous commands resolve as brake and latch a fault
      if (brake) begin
        fault_d = fault_q | accelerate;
        speed_d = (spd_x < BRK_X) ? '0
                : SPEED_W'(spd_x - BRK_X);
      end else if (accelerate) begin
        speed_d = (sum_x > MAX_X) ? MAX_X[SPEED_W-1:0]
                : sum_x[SPEED_W-1:0];
      end else begin
        speed_d = (spd_x < DRG_X) ? '0
                : SPEED_W'(spd_x - DRG_X);
      end
    end
  end

  always_comb begin
    obs_d  = obs_q;
    dcnt_d = '0;
    if (s2_q != obs_q) begin
      if (dcnt_q == DLAST) begin
        obs_d = s2_q;
      end else begin
        dcnt_d = dcnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      speed_q  <= '0;
      pcnt_q   <= '0;
      update_q <= 1'b0;
      fault_q  <= 1'b0;
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      obs_q    <= 1'b0;
      dcnt_q   <= '0;
    end else begin
      speed_q  <= speed_d;
      pcnt_q   <= pcnt_d;
      update_q <= update_d;
      fault_q  <= fault_d;
      s1_q     <= obstacle_raw;
      s2_q     <= s1_q;
      obs_q    <= obs_d;
      dcnt_q   <= dcnt_d;
    end
  end

  assign speed    = speed_q;
  assign obstacle = obs_q;
  assign moving   = (speed_q != '0);
  assign update   = update_q;
  assign fault    = fault_q;

endmodule

// File: tb/tb_vehicle_plant.sv
// Directed bench for vehicle_plant with hand-computed expectations
// checked by immediate assertions.
module tb_vehicle_plant;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       enable;
  logic       accelerate;
  logic       brake;
  logic       load_en;
  logic [7:0] load_value;
  logic       obstacle_raw;
  logic [7:0] speed;
  logic       obstacle;
  logic       moving;
  logic       update;
  logic       fault;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  vehicle_plant dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .enable       (enable),
    .accelerate   (accelerate),
    .brake        (brake),
    .load_en      (load_en),
    .load_value   (load_value),
    .obstacle_raw (obstacle_raw),
    .speed        (speed),
    .obstacle     (obstacle),
    .moving       (moving),
    .update       (update),
    .fault        (fault)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input int obs,
                     input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d",
             tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_speed"}, int'(speed), 0);
    chk({tag, "_obst"}, int'(obstacle), 0);
    chk({tag, "_upd"}, int'(update), 0);
    chk({tag, "_fault"}, int'(fault), 0);
    chk({tag, "_moving"}, int'(moving), 0);
  endtask

  initial begin
    reset_n      = 1'b0;
    enable       = 1'b0;
    accelerate   = 1'b0;
    brake        = 1'b0;
    load_en      = 1'b0;
    load_value   = 8'd0;
    obstacle_raw = 1'b0;
    step();
    chk_all_zero("reset");

    // ramp: tick every 4th edge, speed = ticks so far
    reset_n    = 1'b1;
    enable     = 1'b1;
    accelerate = 1'b1;
    for (int k = 1; k <= 48; k++) begin
      step();
      chk("ramp_upd", int'(update), (k % 4 == 0) ? 1 : 0);
      chk("ramp_speed", int'(speed), k / 4);
      if (k == 3) chk("ramp_still", int'(moving), 0);
      if (k == 4) chk("ramp_moving", int'(moving), 1);
    end
    chk("ramp_end", int'(speed), 12);
    chk("ramp_fault", int'(fault), 0);

    // saturation at the ceiling
    load_en    = 1'b1;
    load_value = 8'd39;
    step();
    load_en = 1'b0;
    chk("ld39_speed", int'(speed), 39);
    chk("ld39_upd", int'(update), 1);
    for (int t = 0; t < 3; t++) begin
      step(); step(); step();
      chk("sat_noupd", int'(update), 0);
      step();
      chk("sat_speed", int'(speed), 40);
      chk("sat_upd", int'(update), 1);
    end

    // load clamps to the ceiling
    load_en    = 1'b1;
    load_value = 8'd200;
    step();
    load_en = 1'b0;
    chk("ldclamp", int'(speed), 40);

    // braking down to zero
    accelerate = 1'b0;
    brake      = 1'b1;
    load_en    = 1'b1;
    load_value = 8'd3;
    step();
    load_en = 1'b0;
    chk("ld3_speed", int'(speed), 3);
    repeat (4) step();
    chk("brk1_speed", int'(speed), 1);
    chk("brk1_moving", int'(moving), 1);
    repeat (4) step();
    chk("brk2_speed", int'(speed), 0);
    chk("brk2_moving", int'(moving), 0);
    repeat (4) step();
    chk("brk3_speed", int'(speed), 0);
    chk("brk3_upd", int'(update), 1);

    // conflicting commands
    brake      = 1'b0;
    load_en    = 1'b1;
    load_value = 8'd10;
    step();
    load_en = 1'b0;
    chk("ld10_speed", int'(speed), 10);
    chk("ld10_fault", int'(fault), 0);
    accelerate = 1'b1;
    brake      = 1'b1;
    repeat (4) step();
    chk("both_speed", int'(speed), 8);
    chk("both_fault", int'(fault), 1);
    accelerate = 1'b0;
    brake      = 1'b0;
    step(); step();
    chk("fault_sticky", int'(fault), 1);

    // prescaler frozen while disabled (pcnt is 2 here)
    accelerate = 1'b1;
    enable     = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      chk("frz_speed", int'(speed), 8);
      chk("frz_upd", int'(update), 0);
    end
    enable = 1'b1;
    step();
    chk("resume_noupd", int'(update), 0);
    step();
    chk("resume_speed", int'(speed), 9);
    chk("resume_upd", int'(update), 1);

    // obstacle rise after exactly 5 edges
    obstacle_raw = 1'b1;
    repeat (4) step();
    chk("obs_rise4", int'(obstacle), 0);
    step();
    chk("obs_rise5", int'(obstacle), 1);
    obstacle_raw = 1'b0;
    repeat (4) step();
    chk("obs_fall4", int'(obstacle), 1);
    step();
    chk("obs_fall5", int'(obstacle), 0);

    // short pulse rejected
    obstacle_raw = 1'b1;
    step(); step();
    obstacle_raw = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step();
      chk("glitch", int'(obstacle), 0);
    end

    // reset mid-debounce clears everything
    obstacle_raw = 1'b1;
    repeat (3) step();
    chk("pre_rst_fault", int'(fault), 1);
    reset_n = 1'b0;
    step();
    chk_all_zero("midrst");
    reset_n = 1'b1;
    obstacle_raw = 1'b0;
    enable = 1'b0;
    step();
    chk("post_rst_obs", int'(obstacle), 0);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule

// File: doc/vehicle_plant.md
# vehicle_plant

Closed-loop vehicle model and sensor front end on the opposite side of the drive-control FSM. It consumes the controller's `accelerate`/`brake` commands and integrates them into a saturating speed value on a prescaled update tick. It also debounces a raw obstacle sensor, and returns `speed` and `obstacle` to the controller. Bench and integration use it as the plant; the load port seeds an initial speed.

## Interface
- `SPEED_W`, 8: width of speed value
- `SPEED_MAX`, 40: speed saturation ceiling; must be ≤ 2^SPEED_W−1
- `TICK_DIV`, 4: enabled clock cycles per speed update; ≥ 1
- `ACCEL_STEP`, 1: speed increment per tick while accelerating
- `BRAKE_STEP`, 2: speed decrement per tick while braking
- `DRAG_STEP`, 0: speed decrement per tick while coasting
- `DEBOUNCE`, 3: consecutive synchronized cycles required to change `obstacle`; ≥ 1
- `clk`, in, 1: sole clock, rising edge
- `reset_n`, in, 1: one clock; reset is synchronous and active-low
- `enable`, in, 1: prescaler runs only while high
- `accelerate`, in, 1: controller command
- `brake`, in, 1: controller command
- `load_en`, in, 1: one-cycle request to overwrite speed
- `load_value`, in, SPEED_W: speed to load
- `obstacle_raw`, in, 1: asynchronous sensor level
- `speed`, out, SPEED_W: registered current speed
- `obstacle`, out, 1: registered debounced obstacle flag
- `moving`, out, 1: `speed != 0`, decoded from the speed register
- `update`, out, 1: one-cycle pulse, high the cycle a new speed value first appears
- `fault`, out, 1: sticky; set when `accelerate` and `brake` are both high at a tick

## Operation
- Reset (`reset_n` low at an edge): `speed`=0, `obstacle`=0, `update`=0, `fault`=0, `moving`=0. The prescaler, debounce counter and both sync flops are cleared to 0. Reset overrides every other action, including mid-tick and mid-debounce.
- Prescaler `pcnt` (0..TICK_DIV−1):
  - While `enable` is high it increments; the tick is the cycle with `pcnt==TICK_DIV−1`, and `pcnt` wraps to 0 on that edge.
  - While `enable` is low, `pcnt` holds and no tick occurs.
  - With TICK_DIV=1, every enabled cycle is a tick.
- Speed update on a tick edge, priority high to low:
  - `load_en`: `speed` ← min(`load_value`, SPEED_MAX), `pcnt` ← 0, `update` ← 1. Load applies on any cycle, tick or not, enabled or not.
  - `accelerate && brake`: treat as brake; `fault` ← 1.
  - `brake`: `speed` ← max(speed−BRAKE_STEP, 0).
  - `accelerate`: `speed` ← min(speed+ACCEL_STEP, SPEED_MAX).
  - neither: `speed` ← max(speed−DRAG_STEP, 0).
  - `update` ← 1 on every tick, even if the value is unchanged. Otherwise `update` ← 0.
- Arithmetic is done in SPEED_W+1 bits; results clamp and never wrap.
- Obstacle path:
  - `s1` ← `obstacle_raw`, then `s2` ← `s1`.
  - If `s2 != obstacle`: `dcnt` increments. When `dcnt==DEBOUNCE−1`, `obstacle` ← `s2` and `dcnt` ← 0.
  - If `s2 == obstacle`: `dcnt` ← 0.
  - The path is independent of `enable`.
- `fault` clears only on reset.

## Timing
- Commands are sampled only on the tick cycle; the new `speed` is visible on the following cycle, coincident with `update`=1.
- From reset release with `enable` held high, the first tick is the TICK_DIV-th cycle, so `update` first pulses on cycle TICK_DIV+1.
- Load latency is 1 cycle. The next tick comes TICK_DIV enabled cycles after the load.
- Obstacle latency: `obstacle` changes on the (2+DEBOUNCE)-th edge after the first edge sampling a stable new raw level. The default is 5.
- Raw pulses that leave `s2` different for fewer than DEBOUNCE cycles are rejected.
- At saturation (speed=SPEED_MAX, or 0 while braking/coasting), the tick still pulses `update` and `speed` is unchanged.

## Test plan
- Reset then `enable`=1, `accelerate`=1 for 48 cycles → `update` on cycles 5, 9, …; `speed` 1, 2, … reaching 12 after 12 ticks; `moving`=1 from the first tick.
- Load 39, `accelerate`=1 for 3 ticks → speed 40, 40, 40; `update` pulses each tick; never 41 or wrap.
- Load 3, `brake`=1 → speed 1 then 0 then 0; `moving` falls with the 0.
- `accelerate`=`brake`=1 at a tick with speed 10 → speed 8, `fault`=1, still 1 after inputs drop; clears only on `reset_n` low.
- `obstacle_raw` 0→1 held → `obstacle`=1 exactly 5 edges later. A 2-cycle raw pulse → `obstacle` stays 0.
- `enable`=0 for 10 cycles mid-count with `accelerate`=1 → speed frozen, no `update`. `reset_n` low mid-debounce → all outputs 0 next cycle.
